dense_layer_seq: RTL and testbench
==================================

Name: dense_layer_seq

Overview:
Sequential, resource-shared successor to the combinational dense layer. It computes result[b][m] = act(bias[m] + sum over n of weights[m][n]*inputs[b][n]) for B batches, M neurons and N inputs, using one signed MAC iterated over time. It adds a per-neuron bias, an optional ReLU, saturating output and a start/busy/done handshake. It sits between operand buffers and the next layer in the NN datapath.

Parameters:
B, 2, batch count (>=1)
M, 3, neuron count (>=1)
N, 4, inputs per neuron (>=1)
WIDTH, 16, signed operand width; results are 2*WIDTH signed

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin computation; honoured only in IDLE
relu_en  input  1  ReLU enable; latched on accepted start
weights  input  [M][N] x WIDTH signed  weight matrix
inputs  input  [B][N] x WIDTH signed  input vectors
bias  input  [M] x 2*WIDTH signed  per-neuron bias
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse when all results are written
result  output  [B][M] x 2*WIDTH signed  registered outputs

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, all result entries 0, counters b/m/n=0, accumulator 0, latched relu 0.
- weights, inputs and bias are read live. The source must hold them stable from the start edge until done. Changes while busy give undefined results; the bench must not do this.
- States:
  - IDLE: on start=1, go to MAC; b=m=n=0; acc <= sign-extended bias[0]; latch relu_en.
  - MAC: acc <= acc + weights[m][n]*inputs[b][n]. If n==N-1, go to WRITE with n <= 0. Otherwise n++.
  - WRITE: result[b][m] <= sat(relu ? max(acc,0) : acc). Advance m, then wrap m to 0 and advance b. acc <= bias[next m]. If b==B-1 and m==M-1, go to DONE; otherwise go to MAC.
  - DONE: done=1 for this cycle only, then go to IDLE.
- Arithmetic:
  - Products are full 2*WIDTH signed.
  - The accumulator is 2*WIDTH + clog2(N+1) bits signed, so there is no internal overflow.
  - sat() clamps to [-2^(2W-1), 2^(2W-1)-1].
  - ReLU is applied before saturation. A negative value gives 0.
- Latency: done is high in the cycle following B*M*(N+1)+1 rising edges after the edge that samples start (31 for the defaults). It is never asserted otherwise.
- Result update timing: result entries update progressively, one per WRITE cycle. Entries not yet rewritten keep their previous run's values. All entries are valid and stable from done until the next accepted start.
- start while busy (MAC/WRITE/DONE) is ignored and not queued. start held high in IDLE immediately after DONE begins a new run.
- relu_en changes while busy have no effect on the current run.
- rst mid-run aborts immediately: IDLE, results cleared, no done pulse.

Test Plan:
- Defaults; weights rows {1,2,3,4},{-1,0,2,1},{3,-2,1,0}; inputs {1,2,3,4},{2,-1,0,3}; bias 0; relu_en=0; pulse start -> done at edge 31; result[0]={30,9,2}, result[1]={12,1,8}; busy high for exactly 31 cycles.
- Same operands, bias {0,-10,0}, relu_en=0 -> result[0]={30,-1,2}, result[1]={12,-9,8}. Repeat with relu_en=1 -> result[0]={30,0,2}, result[1]={12,0,8}.
- All weights and inputs -32768, bias 0, relu_en=0 -> every result saturates to 2147483647. All weights -32768, all inputs 32767, bias -1 -> every result is -2147483648 (sum is -4294836225, saturated).
- Pulse start again at cycles 5 and 20 of a run, and toggle relu_en mid-run -> single done at edge 31, results identical to the unperturbed run.
- Assert rst at cycle 12 of a run -> busy=0, done=0, all results 0 asynchronously; a fresh start then completes normally with the first scenario's values.
- B=1, M=1, N=1, WIDTH=8, weight -3, input 5, bias 2 -> done at edge 3, result -13; with relu_en=1, result 0.

Source files
------------

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: one signed MAC iterated over batches, neurons and inputs,
// with per-neuron bias, optional ReLU, saturation to 2*WIDTH and a start/busy/done handshake.
module dense_layer_seq #(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      relu_en,
  input  logic signed [WIDTH-1:0]   weights [M][N],
  input  logic signed [WIDTH-1:0]   inputs  [B][N],
  input  logic signed [2*WIDTH-1:0] bias    [M],
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] result  [B][M]
);

  localparam int RW = 2 * WIDTH;
  localparam int AW = RW + $clog2(N + 1);
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [BW-1:0] B_LAST = BW'(B - 1);
  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);

  localparam logic signed [AW-1:0] SAT_HI = AW'({1'b0, {(RW - 1){1'b1}}});
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE,
    S_FIN
  } state_t;

  state_t                 r_state;
  logic [BW-1:0]          r_b;
  logic [MW-1:0]          r_m;
  logic [NW-1:0]          r_n;
  logic signed [AW-1:0]   r_acc;
  logic                   r_relu;
  logic                   r_done;

  logic signed [RW-1:0]   w_prod;
  logic [MW-1:0]          w_next_m;

  function automatic logic signed [AW-1:0] relu_f(input logic signed [AW-1:0] v,
                                                  input logic en);
    return (en && (v < 0)) ? '0 : v;
  endfunction

  function automatic logic signed [RW-1:0] sat_f(input logic signed [AW-1:0] v);
    if (v > SAT_HI) return SAT_HI[RW-1:0];
    if (v < SAT_LO) return SAT_LO[RW-1:0];
    return v[RW-1:0];
  endfunction

  // Operands are sign-extended to the full product width before multiplying.
  assign w_prod   = RW'(weights[r_m][r_n]) * RW'(inputs[r_b][r_n]);
  assign w_next_m = (r_m == M_LAST) ? '0 : r_m + 1'b1;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_acc   <= '0;
      r_relu  <= 1'b0;
      r_done  <= 1'b0;
      for (int b = 0; b < B; b++)
        for (int m = 0; m < M; m++)
          result[b][m] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_MAC;
            r_b     <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_acc   <= AW'(bias[0]);
            r_relu  <= relu_en;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + AW'(w_prod);
          if (r_n == N_LAST) begin
            r_n     <= '0;
            r_state <= S_WRITE;
          end else begin
            r_n <= r_n + 1'b1;
          end
        end
        S_WRITE: begin
          result[r_b][r_m] <= sat_f(relu_f(r_acc, r_relu));
          r_acc            <= AW'(bias[w_next_m]);
          r_m              <= w_next_m;
          if (r_m == M_LAST) begin
            if (r_b == B_LAST) begin
              r_b     <= '0;
              r_state <= S_FIN;
            end else begin
              r_b     <= r_b + 1'b1;
              r_state <= S_MAC;
            end
          end else begin
            r_state <= S_MAC;
          end
        end
        S_FIN: begin
          // done is registered, so it rises on the edge that returns to IDLE.
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench for dense_layer_seq: stimulus pushes model results, a negedge monitor checks on done.
module tb_dense_layer_seq;
  localparam int B = 2, M = 3, N = 4, W = 16, RW = 32, LAT = 31;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst, start, relu_en;
  logic signed [W-1:0]  w   [M][N];
  logic signed [W-1:0]  x   [B][N];
  logic signed [RW-1:0] bias[M];
  logic busy, done;
  logic signed [RW-1:0] res [B][M];

  logic s_start, s_relu, s_busy, s_done;
  logic signed [7:0]  s_w   [1][1];
  logic signed [7:0]  s_x   [1][1];
  logic signed [15:0] s_bias[1];
  logic signed [15:0] s_res [1][1];

  dense_layer_seq #(.B(B), .M(M), .N(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
    .weights(w), .inputs(x), .bias(bias),
    .busy(busy), .done(done), .result(res)
  );

  dense_layer_seq #(.B(1), .M(1), .N(1), .WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .relu_en(s_relu),
    .weights(s_w), .inputs(s_x), .bias(s_bias),
    .busy(s_busy), .done(s_done), .result(s_res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, busy_cnt = 0, sc = 0;
  typedef logic [B*M*RW-1:0] res_t;
  res_t exp_q[$];
  int   cyc_q[$];

  int wp[M][N] = '{'{1, 2, 3, 4}, '{-1, 0, 2, 1}, '{3, -2, 1, 0}};
  int xp[B][N] = '{'{1, 2, 3, 4}, '{2, -1, 0, 3}};

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic res_t model(input logic r);
    res_t o;
    longint s;
    o = '0;
    for (int b = 0; b < B; b++)
      for (int m = 0; m < M; m++) begin
        s = longint'(bias[m]);
        for (int n = 0; n < N; n++) s += longint'(w[m][n]) * longint'(x[b][n]);
        if (r && s < 0) s = 0;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        o[(b*M+m)*RW +: RW] = s[RW-1:0];
      end
    return o;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding run.
  always @(negedge clk) begin
    res_t e;
    int   ec;
    if (busy) busy_cnt++;
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("done_cycle", cyc, ec);
        chk("busy_cycles", busy_cnt, LAT);
        for (int b = 0; b < B; b++)
          for (int m = 0; m < M; m++)
            chk($sformatf("res[%0d][%0d]", b, m), longint'(res[b][m]),
                longint'($signed(e[(b*M+m)*RW +: RW])));
      end
      busy_cnt = 0;
    end
  end

  task automatic set_ops(input int kind);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++)
        case (kind)
          0: w[m][n] = 16'(wp[m][n]);
          1, 2: w[m][n] = 16'sh8000;
          default: w[m][n] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
        endcase
    for (int b = 0; b < B; b++)
      for (int n = 0; n < N; n++)
        case (kind)
          0: x[b][n] = 16'(xp[b][n]);
          1: x[b][n] = 16'sh8000;
          2: x[b][n] = 16'sh7fff;
          default: x[b][n] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
        endcase
  endtask

  task automatic go(input logic r);
    relu_en = r;
    start   = 1'b1;
    @(posedge clk); #1;
    sc    = cyc;
    start = 1'b0;
    exp_q.push_back(model(r));
    cyc_q.push_back(sc + LAT);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (k >= 200) chk("timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic small_run(input logic r, input longint expv);
    int k = 0;
    s_relu  = r;
    s_start = 1'b1;
    @(posedge clk); #1;
    sc      = cyc;
    s_start = 1'b0;
    while (!s_done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("small_latency", cyc - sc, 3);
    chk("small_result", longint'(s_res[0][0]), expv);
    @(posedge clk); #1;
  endtask

  task automatic pulse_at(input int rel, input logic r);
    while (cyc < sc + rel - 1) begin
      @(posedge clk); #1;
    end
    start   = 1'b1;
    relu_en = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; s_start = 1'b0; s_relu = 1'b0;
    set_ops(0);
    bias = '{0, 0, 0};
    s_w[0][0] = -8'sd3; s_x[0][0] = 8'sd5; s_bias[0] = 16'sd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    for (int b = 0; b < B; b++)
      for (int m = 0; m < M; m++) chk("rst_res", longint'(res[b][m]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    go(0); wait_done();
    bias = '{0, -10, 0};
    go(0); wait_done();
    go(1); wait_done();

    bias = '{0, 0, 0};
    set_ops(1); go(0); wait_done();
    bias = '{-1, -1, -1};
    set_ops(2); go(0); wait_done();

    // Restarts and relu_en toggles during a run must be ignored.
    set_ops(0);
    bias = '{0, -10, 0};
    go(0);
    pulse_at(5, 1'b1);
    pulse_at(20, 1'b0);
    relu_en = 1'b1;
    wait_done();
    repeat (5) @(posedge clk);
    #1;

    bias = '{0, 0, 0};
    go(0);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int b = 0; b < B; b++)
      for (int m = 0; m < M; m++) chk("abort_res", longint'(res[b][m]), 0);
    exp_q.delete();
    cyc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    busy_cnt = 0;
    @(posedge clk); #1;
    go(0); wait_done();

    // start held through done launches a second run on the following edge.
    set_ops(3);
    for (int m = 0; m < M; m++) bias[m] = 32'($urandom);
    relu_en = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    sc = cyc;
    exp_q.push_back(model(1'b1)); cyc_q.push_back(sc + LAT);
    exp_q.push_back(model(1'b1)); cyc_q.push_back(sc + 2 * LAT + 1);
    while (cyc < sc + LAT + 1) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done();

    repeat (6) begin
      set_ops(3);
      for (int m = 0; m < M; m++)
        bias[m] = ($urandom_range(0, 3) == 0) ? 32'sh80000000 : 32'($urandom);
      go(1'($urandom_range(0, 1)));
      wait_done();
    end

    small_run(1'b0, -13);
    small_run(1'b1, 0);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
